serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder controller that sits directly upstream of the team's 1-bit full adder `adder` (ports a, b, cin, sum, carry).
- Accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first into one `adder` instance, one bit per clock.
- Registers the carry between bits and collects the sum bits into a result register.
- Presents the WIDTH-bit sum and carry-out to a downstream consumer over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  operands and cin_in are valid.
- start_ready  output  1  block can accept operands (high only in IDLE).
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- cin_in  input  1  initial carry-in.
- res_valid  output  1  sum_out/cout_out hold a completed result.
- res_ready  input  1  consumer accepts the result.
- sum_out  output  WIDTH  result register.
- cout_out  output  1  final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, sum_out=0, cout_out=0, internal shift registers, carry flop and counter all 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: load op_a/op_b into shift registers SA/SB, carry<=cin_in, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN: the `adder` instance is driven a=SA[0], b=SB[0], cin=carry. Each edge:
  - SA, SB shift right by one.
  - sum_out <= {adder.sum, sum_out[WIDTH-1:1]}.
  - carry <= adder.carry.
  - cnt <= cnt+1.
  - The edge where cnt==WIDTH-1 also sets cout_out <= adder.carry and moves to DONE.
- DONE:
  - res_valid=1.
  - sum_out and cout_out are held stable while res_ready=0.
  - On an edge with res_ready=1: go to IDLE, res_valid=0.
- Latency: operands accepted at edge k; res_valid high after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum.
- Result visibility: sum_out changes during RUN and is meaningful only while res_valid=1. It retains the last result in IDLE until the next accept.
- Arithmetic: modulo 2^WIDTH sum; cout_out is the true carry out of bit WIDTH-1.
- start_valid is ignored in RUN and DONE (start_ready=0).
- Simultaneous res_ready and start_valid in DONE: the result is consumed, the start is not accepted, and it can be accepted on the following IDLE cycle (one-cycle bubble).
- start_valid is not required to stay high after acceptance; op_a, op_b and cin_in are sampled only at the accept edge.
- WIDTH=1: RUN lasts exactly one cycle.
- rst asserted in any state, including mid-RUN, returns immediately to the reset values. A partial result is never flagged valid.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at the accept edge.
  - If sub=1, op_b is loaded bit-inverted and the carry flop loads 1, ignoring cin_in, giving A-B.
  - cout_out=1 means no borrow.
- When undefined: no sub port, and the block is addition only.

Test Plan (WIDTH=8):
- Reset: assert rst for 3 cycles with random inputs -> start_ready=1, res_valid=0, busy=0, sum_out=0x00, cout_out=0.
- Basic add: op_a=0x5A, op_b=0x33, cin_in=0 accepted at edge k -> res_valid rises after edge k+8, sum_out=0x8D, cout_out=0.
- Carry chain:
  - 0xFF+0x01, cin_in=0 -> sum_out=0x00, cout_out=1.
  - 0xFF+0x00, cin_in=1 -> sum_out=0x00, cout_out=1.
  - 0x00+0x00, cin_in=1 -> sum_out=0x01, cout_out=0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid, with start_valid=1 throughout -> sum_out/cout_out stable, start_ready=0. When res_ready=1, IDLE follows and the next operands are accepted one cycle later.
- Reset mid-operation: assert rst 3 cycles into RUN of 0xAA+0x55 -> immediate IDLE with res_valid=0. A following 0x12+0x34 gives 0x46, cout_out=0.
- With SERIAL_ADD_SUB_EN:
  - sub=1, 0x10-0x01 -> 0x0F, cout_out=1.
  - sub=1, 0x01-0x02 -> 0xFF, cout_out=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands in over valid/ready, LSB-first through one 1-bit adder,
// result out over valid/ready after WIDTH cycles. Define SERIAL_ADD_SUB_EN to add the sub port (A-B).

module adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             last_bit;
   logic             add_sum;
   logic             add_carry;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic [WIDTH:0]   sum_ext;

   adder u_adder (
      .a     (sa[0]),
      .b     (sb[0]),
      .cin   (carry),
      .sum   (add_sum),
      .carry (add_carry)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   // Slicing the extended vector keeps the shift legal when WIDTH is 1.
   assign sum_ext  = {add_sum, sum_out};

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction as A + ~B + 1; a final carry of 1 means no borrow.
   assign b_load = sub ? ~op_b : op_b;
   assign c_load = sub ? 1'b1  : cin_in;
`else
   assign b_load = op_b;
   assign c_load = cin_in;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_valid) state_nxt = RUN;
         RUN:     if (last_bit)    state_nxt = DONE;
         DONE:    if (res_ready)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state == IDLE);
      res_valid   = (state == DONE);
      busy        = (state == RUN) || (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa       <= '0;
         sb       <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  sa    <= op_a;
                  sb    <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sa      <= sa >> 1;
               sb      <= sb >> 1;
               sum_out <= sum_ext[WIDTH:1];
               carry   <= add_carry;
               cnt     <= cnt + CNT_W'(1);
               if (last_bit) cout_out <= add_carry;
            end
            default: ;
         endcase
      end
   end
endmodule
